// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX datapath (FIFO + TX controller) between
// byte-stream clients; drains the datapath before switching frame format.
module uart_tx_arbiter #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_BURST   = 4,
  localparam int unsigned GW         = $clog2(NUM_CLIENTS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CLIENTS-1:0]          req_valid,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_CLIENTS-1:0]          req_last,
  output logic [NUM_CLIENTS-1:0]          req_ready,
  input  logic [NUM_CLIENTS*2-1:0]        cfg_parity,
  input  logic [NUM_CLIENTS-1:0]          cfg_stop,
  input  logic                            full,
  input  logic                            empty,
  input  logic                            tx_busy,
  output logic                            wr_en,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic [1:0]                      parity_sel,
  output logic                            stop_bits,
  output logic                            grant_valid,
  output logic [GW-1:0]                   grant_id
);

  localparam int unsigned BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, CFG, STREAM} state_t;

  state_t                state;
  state_t                state_nx;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         sel_id;
  logic [GW-1:0]         cand;
  logic                  sel_found;
  logic [2:0]            pend_cfg;
  logic [BCW-1:0]        burst_cnt;
  logic                  idle_seen;
  logic                  dp_idle;
  logic                  xfer;
  logic                  burst_end;
  logic                  cfg_match;

  logic [DATA_WIDTH-1:0] data_arr [NUM_CLIENTS];
  logic [2:0]            cfg_arr  [NUM_CLIENTS];

  // Per-client views of the packed request and frame-config buses
  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign cfg_arr[i]  = {cfg_parity[2*i +: 2], cfg_stop[i]};
  end

  // Round-robin pick: first requester after last_grant, wrapping around
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_CLIENTS; off++) begin
      cand = GW'((32'(last_grant) + off) % NUM_CLIENTS);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign dp_idle   = empty & ~tx_busy;
  assign cfg_match = (cfg_arr[sel_id] == {parity_sel, stop_bits});
  assign xfer      = (state == STREAM) & req_valid[grant_id] & ~full;
  assign burst_end = (state == STREAM) &
                     (~req_valid[grant_id] |
                      (xfer & (req_last[grant_id] | (burst_cnt == BCW'(MAX_BURST-1)))));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; DRAIN needs two consecutive idle samples to cover the
  // gap between the FIFO pop and tx_busy rising
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sel_found) state_nx = cfg_match ? STREAM : DRAIN;
      DRAIN:   if (dp_idle && idle_seen) state_nx = CFG;
      CFG:     state_nx = STREAM;
      STREAM:  if (burst_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic; reset squashes the handshake in the same cycle
  always_comb begin
    req_ready   = '0;
    wr_en       = 1'b0;
    grant_valid = 1'b0;
    if (state == STREAM && !reset) begin
      grant_valid         = 1'b1;
      req_ready[grant_id] = ~full;
      wr_en               = xfer;
    end
  end

  assign wr_data = data_arr[grant_id];

  // Grant bookkeeping, drain qualifier and applied frame configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GW'(NUM_CLIENTS-1);
      grant_id   <= '0;
      pend_cfg   <= '0;
      burst_cnt  <= '0;
      idle_seen  <= 1'b0;
      parity_sel <= 2'b00;
      stop_bits  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idle_seen <= 1'b0;
          burst_cnt <= '0;
          if (sel_found) begin
            grant_id <= sel_id;
            pend_cfg <= cfg_arr[sel_id];
          end
        end
        DRAIN:   idle_seen <= dp_idle;
        CFG:     {parity_sel, stop_bits} <= pend_cfg;
        STREAM: begin
          if (burst_end) begin
            last_grant <= grant_id;
            burst_cnt  <= '0;
          end else if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed client streams, expected FIFO writes
// queued up front and checked by an independent write monitor.
module tb_uart_tx_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  cfg_parity;
  logic [N-1:0]    cfg_stop;
  logic            full;
  logic            empty;
  logic            tx_busy;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [1:0]      parity_sel;
  logic            stop_bits;
  logic            grant_valid;
  logic [1:0]      grant_id;

  uart_tx_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .cfg_parity (cfg_parity),
    .cfg_stop   (cfg_stop),
    .full       (full),
    .empty      (empty),
    .tx_busy    (tx_busy),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .parity_sel (parity_sel),
    .stop_bits  (stop_bits),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] cid;
    logic [1:0] par;
    logic       stop;
    logic [7:0] data;
  } exp_t;

  exp_t          expq[$];
  int            wr_cyc[$];
  int            n_tests;
  int            n_fail;
  int            cyc;
  logic [DW-1:0] cmem  [N][DEPTH];
  logic          clast [N][DEPTH];
  int            crd   [N];
  int            cwr   [N];
  logic [N-1:0]  acc;
  logic          reset_nx, full_nx, empty_nx, busy_nx;
  logic [2*N-1:0] par_nx;
  logic [N-1:0]  stop_nx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] c, input logic [7:0] d, input logic l);
    cmem[c][4'(cwr[c])]  = d;
    clast[c][4'(cwr[c])] = l;
    cwr[c]++;
  endtask

  task automatic expect_wr(input logic [1:0] c, input logic [1:0] par, input logic stop,
                           input logic [7:0] d);
    exp_t e;
    e.cid  = c;
    e.par  = par;
    e.stop = stop;
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic do_reset();
    reset_nx = 1'b1;
    full_nx  = 1'b0;
    empty_nx = 1'b1;
    busy_nx  = 1'b0;
    par_nx   = '0;
    stop_nx  = '0;
    for (int i = 0; i < N; i++) begin
      crd[2'(i)] = 0;
      cwr[2'(i)] = 0;
    end
    repeat (3) tick();
    reset_nx = 1'b0;
    tick();
  endtask

  task automatic wait_wr(input string name, input int budget);
    int k = 0;
    while (wr_en !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    if (wr_en !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no wr_en, expected one within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (expq.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    repeat (4) tick();
    chk({name, "_pending"}, 32'(expq.size()), 32'd0);
  endtask

  // Client model + input driver: all DUT inputs change 1 time unit after posedge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++)
        if (acc[2'(i)] && crd[2'(i)] != cwr[2'(i)]) crd[2'(i)]++;
      reset      = reset_nx;
      full       = full_nx;
      empty      = empty_nx;
      tx_busy    = busy_nx;
      cfg_parity = par_nx;
      cfg_stop   = stop_nx;
      for (int i = 0; i < N; i++) begin
        req_valid[2'(i)]     = (crd[2'(i)] != cwr[2'(i)]);
        req_data[i*DW +: DW] = cmem[2'(i)][4'(crd[2'(i)])];
        req_last[2'(i)]      = clast[2'(i)][4'(crd[2'(i)])];
      end
    end
  end

  // Write monitor: every FIFO write is matched against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (wr_en === 1'b1) begin
        wr_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got 0x%0h from client %0d, expected no write",
                   wr_data, grant_id);
        end else begin
          e = expq.pop_front();
          chk("wr_data",   32'(wr_data),    32'(e.data));
          chk("wr_grant",  32'(grant_id),   32'(e.cid));
          chk("wr_parity", 32'(parity_sel), 32'(e.par));
          chk("wr_stop",   32'(stop_bits),  32'(e.stop));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    acc     = '0;
    reset = 1'b1; full = 1'b0; empty = 1'b1; tx_busy = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; cfg_parity = '0; cfg_stop = '0;
    for (int i = 0; i < N; i++) begin
      crd[2'(i)] = 0;
      cwr[2'(i)] = 0;
    end
    do_reset();

    // Reset values
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_wr_en",       32'(wr_en),       32'd0);
    chk("rst_req_ready",   32'(req_ready),   32'd0);
    chk("rst_parity",      32'(parity_sel),  32'd0);
    chk("rst_stop",        32'(stop_bits),   32'd0);
    chk("rst_grant_id",    32'(grant_id),    32'd0);

    // 1: single byte from client 2, matching config
    push(2'd2, 8'hA5, 1'b1);
    expect_wr(2'd2, 2'b00, 1'b0, 8'hA5);
    t0 = cyc;
    tick();
    chk("t1_idle_wr_en", 32'(wr_en), 32'd0);
    chk("t1_idle_gv",    32'(grant_valid), 32'd0);
    tick();
    chk("t1_wr_en",    32'(wr_en), 32'd1);
    chk("t1_ready",    32'(req_ready), 32'h4);
    chk("t1_gv",       32'(grant_valid), 32'd1);
    chk("t1_latency",  32'(cyc - t0), 32'd2);
    tick();
    chk("t1_gv_after", 32'(grant_valid), 32'd0);
    chk("t1_wr_after", 32'(wr_en), 32'd0);
    wait_done("t1", 20);

    // 2: all clients request, one byte each -> 0,1,2,3,0 with a gap cycle
    do_reset();
    wr_cyc.delete();
    for (int c = 0; c < N; c++) begin
      push(2'(c), 8'(8'h10 + c), 1'b1);
      expect_wr(2'(c), 2'b00, 1'b0, 8'(8'h10 + c));
    end
    push(2'd0, 8'h14, 1'b1);
    expect_wr(2'd0, 2'b00, 1'b0, 8'h14);
    wait_done("t2", 40);
    chk("t2_nwrites", 32'(wr_cyc.size()), 32'd5);
    for (int k = 1; k < wr_cyc.size(); k++)
      chk("t2_gap", 32'(wr_cyc[k] - wr_cyc[k-1]), 32'd2);

    // 3: burst cap of 4 with an interleaved client
    do_reset();
    for (int k = 0; k < 10; k++) push(2'd1, 8'(8'h30 + k), 1'b0);
    push(2'd2, 8'h77, 1'b1);
    for (int k = 0; k < 4; k++) expect_wr(2'd1, 2'b00, 1'b0, 8'(8'h30 + k));
    expect_wr(2'd2, 2'b00, 1'b0, 8'h77);
    for (int k = 4; k < 10; k++) expect_wr(2'd1, 2'b00, 1'b0, 8'(8'h30 + k));
    wait_done("t3", 60);

    // 4: full held for 5 cycles mid-burst
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push(2'd3, 8'(8'h40 + k), (k == 5));
      expect_wr(2'd3, 2'b00, 1'b0, 8'(8'h40 + k));
    end
    wait_wr("t4_first", 10);
    full_nx = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t4_stall_wr_en", 32'(wr_en), 32'd0);
      chk("t4_stall_ready", 32'(req_ready), 32'd0);
      chk("t4_stall_gv",    32'(grant_valid), 32'd1);
      chk("t4_stall_gid",   32'(grant_id), 32'd3);
    end
    full_nx = 1'b0;
    tick();
    chk("t4_resume_wr_en", 32'(wr_en), 32'd1);
    wait_done("t4", 40);

    // 5: frame switch waits for a drained, idle datapath
    do_reset();
    par_nx  = 8'b0000_1001;
    stop_nx = 4'b0010;
    push(2'd0, 8'h50, 1'b1);
    push(2'd1, 8'h51, 1'b1);
    expect_wr(2'd0, 2'b01, 1'b0, 8'h50);
    expect_wr(2'd1, 2'b10, 1'b1, 8'h51);
    t0 = cyc;
    wait_wr("t5_first", 12);
    chk("t5_mismatch_latency", 32'(cyc - t0), 32'd5);
    empty_nx = 1'b0;
    busy_nx  = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("t5_busy_parity", 32'(parity_sel), 32'h1);
      chk("t5_busy_ready",  32'(req_ready), 32'd0);
      chk("t5_busy_wr_en",  32'(wr_en), 32'd0);
    end
    empty_nx = 1'b1;
    busy_nx  = 1'b0;
    tick();
    chk("t5_gap1_parity", 32'(parity_sel), 32'h1);
    busy_nx = 1'b1;
    tick();
    chk("t5_gap2_parity", 32'(parity_sel), 32'h1);
    busy_nx = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("t5_drain_parity", 32'(parity_sel), 32'h1);
      chk("t5_drain_wr_en",  32'(wr_en), 32'd0);
    end
    tick();
    chk("t5_cfg_parity", 32'(parity_sel), 32'h2);
    chk("t5_cfg_stop",   32'(stop_bits), 32'd1);
    chk("t5_cfg_wr_en",  32'(wr_en), 32'd1);
    wait_done("t5", 20);

    // 6: reset in the middle of a burst
    do_reset();
    par_nx  = 8'b0011_0000;
    stop_nx = 4'b0100;
    for (int k = 0; k < 8; k++) push(2'd2, 8'(8'h60 + k), 1'b0);
    expect_wr(2'd2, 2'b11, 1'b1, 8'h60);
    wait_wr("t6_first", 12);
    reset_nx = 1'b1;
    tick();
    chk("t6_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    tick();
    chk("t6_rst_parity", 32'(parity_sel), 32'd0);
    chk("t6_rst_stop",   32'(stop_bits), 32'd0);
    chk("t6_rst_gv",     32'(grant_valid), 32'd0);
    chk("t6_rst_wr_en2", 32'(wr_en), 32'd0);
    reset_nx = 1'b0;
    par_nx   = '0;
    stop_nx  = '0;
    crd[2]   = cwr[2];
    push(2'd3, 8'h63, 1'b1);
    push(2'd1, 8'h61, 1'b1);
    expect_wr(2'd1, 2'b00, 1'b0, 8'h61);
    expect_wr(2'd3, 2'b00, 1'b0, 8'h63);
    wait_wr("t6_post", 10);
    chk("t6_post_gid", 32'(grant_id), 32'd1);
    wait_done("t6", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmit datapath (FIFO plus TX controller) between `NUM_CLIENTS` byte-stream requesters. It grants one client at a time for a burst, then forwards that client's bytes into the datapath FIFO write port with full-backpressure. It drives the datapath's `parity_sel` and `stop_bits` from the granted client's frame configuration. When a grant needs a different frame format, it first drains the datapath.

## Interface
**Parameters**
- `NUM_CLIENTS`, 4: number of requesters (≥2).
- `DATA_WIDTH`, 8: byte width; matches datapath `wr_data`.
- `MAX_BURST`, 4: maximum bytes per grant (≥1).
- `GW`, `$clog2(NUM_CLIENTS)`: grant index width (localparam).

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in NUM_CLIENTS: client i has a byte on `req_data[i]`.
- `req_data` in NUM_CLIENTS*DATA_WIDTH: packed; client i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last` in NUM_CLIENTS: byte is last of the client's message.
- `req_ready` out NUM_CLIENTS: byte accepted this cycle when `req_valid[i] & req_ready[i]`.
- `cfg_parity` in NUM_CLIENTS*2: per-client `parity_sel`.
- `cfg_stop` in NUM_CLIENTS: per-client `stop_bits`.
- `full` in 1: from datapath FIFO.
- `empty` in 1: from datapath FIFO.
- `tx_busy` in 1: from datapath.
- `wr_en` out 1: datapath FIFO write strobe.
- `wr_data` out DATA_WIDTH: datapath FIFO write data.
- `parity_sel` out 2: applied frame parity, registered.
- `stop_bits` out 1: applied stop-bit setting, registered.
- `grant_valid` out 1: high in STREAM.
- `grant_id` out GW: current or most recent granted client.

## Operation
- **States:** IDLE, DRAIN, CFG, STREAM.
- **IDLE**
  - If any `req_valid` is set, select the first requester searching from `last_grant+1` with wrap-around.
  - Register `grant_id` and capture that client's `cfg_parity` and `cfg_stop` into `pend_cfg`.
  - If `pend_cfg` equals the applied {`parity_sel`,`stop_bits`}, go to STREAM; otherwise go to DRAIN.
  - If no request is present, stay in IDLE.
- **DRAIN**
  - Wait until `empty & ~tx_busy` holds for 2 consecutive cycles. This covers the one-cycle gap between the FIFO read and the datapath asserting `tx_busy`.
  - Then go to CFG.
  - Request inputs are ignored, and `req_ready` is all-zero.
- **CFG:** load `parity_sel`/`stop_bits` from `pend_cfg` for one cycle, then go to STREAM.
- **STREAM**
  - `req_ready[grant_id] = ~full`; all other `req_ready` bits are 0.
  - `wr_en = req_valid[grant_id] & ~full`, combinational; `wr_data = req_data[grant_id]`.
  - On each transfer, `burst_cnt` increments.
  - The burst ends, and the next state is IDLE with `last_grant <= grant_id` and `burst_cnt <= 0`, on any of:
    - a transfer with `req_last[grant_id]`;
    - a transfer when `burst_cnt == MAX_BURST-1`;
    - `req_valid[grant_id] == 0` in a STREAM cycle.
  - If `full` is high, the arbiter stalls in STREAM with no transfer. This stall does not end the burst.
- **Non-granted clients:** they see `req_ready=0` and must hold their data (valid/ready rule: data is stable while valid & ~ready).
- **Config changes:** `cfg_*` changes by the granted client during STREAM are ignored until its next grant.
- **Reset values:**
  - state IDLE; `last_grant = NUM_CLIENTS-1`, so client 0 wins first.
  - `parity_sel = 2'b00`, `stop_bits = 0`.
  - `grant_valid = 0`, `grant_id = 0`, `burst_cnt = 0`.
  - `wr_en = 0`, `req_ready = 0`.
  - Reset during STREAM or DRAIN aborts immediately with no further `wr_en`. Bytes already written to the FIFO are the datapath's concern.

## Timing
- `req_valid` rise (cfg match, IDLE) → first `wr_en` one cycle later (IDLE cycle + STREAM cycle).
- With a cfg mismatch and the datapath already idle, the first `wr_en` comes at cycle 4 after the request: IDLE, DRAIN ×2, CFG, STREAM.
- Throughput is 1 byte/cycle in STREAM while `~full`.
- Every burst returns through IDLE, so there is at least 1 dead cycle between grants.
- `parity_sel`/`stop_bits` change only in CFG, and only while the datapath has been observed idle for 2 cycles.
- Round-robin fairness: with all clients continuously requesting, each client receives a grant within `NUM_CLIENTS` bursts.

## Test plan
1. **Single byte:** after reset, client 2 presents 0xA5 with last=1 and default cfg → `wr_en` one cycle after the IDLE cycle, `wr_data=0xA5`, `req_ready[2]` high that cycle; then back to IDLE with `grant_valid=0`.
2. **Round-robin:** all 4 clients request continuously with last=1 → grants in order 0,1,2,3,0; one byte each; one IDLE cycle between bursts.
3. **Burst cap:** client 1 sends 10 bytes with no last, `MAX_BURST=4` → 4 writes, release, other grants, regrant; bytes arrive in order and none are lost.
4. **Backpressure:** `full` held high for 5 cycles mid-burst → `wr_en=0` and `req_ready=0` during that time, grant retained; resumes when `full` drops with no byte duplicated.
5. **Config switch:** client 0 uses parity 2'b01; client 1 uses parity 2'b10 with `stop_bits=1`, while FIFO is non-empty and `tx_busy` is high → `parity_sel` is unchanged until `empty & ~tx_busy` holds for 2 cycles; CFG then loads 2'b10/1 and client 1's first `wr_en` follows one cycle later.
6. **Reset mid-burst:** `reset` is asserted in STREAM → next cycle `wr_en=0`, `req_ready=0`, `parity_sel=0`, `stop_bits=0`, `grant_valid=0`; the first post-reset grant goes to the lowest requesting index.
